// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  // Handshake: a requester raises req[i] and keeps it high for as long as it
  // uses the resource; it owns the resource while gnt[i]=1. Dropping req[i]
  // ends the grant at the next edge. timeout marks a forced revocation.
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter8_dec3to8.sv
// Expands the registered winner index into a one-hot grant, gated by valid.
module dec3to8
  import rr_arbiter8_pkg::*;
(
  input  logic [ID_W-1:0]    id,
  input  logic               valid,
  output logic [NUM_REQ-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (valid) onehot[id] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with held grants; optional hold-timeout revocation
// is compiled in with RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter8_if.slave    bus,
  output arb_state_t      dbg_state,
  output logic [ID_W-1:0] dbg_ptr
);
  if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD out of range 1..255");
  end

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] pick_id;
  logic            pick_found;
  logic            hold_expired;

`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  // Counter is zero in the first BUSY cycle, so hitting MAX_HOLD-1 at an edge
  // means MAX_HOLD grant cycles have been seen.
  always_comb begin
    hold_expired = (state_q == BUSY) && bus.req[gnt_id_q] &&
                   (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    timeout_d    = hold_expired;
    hold_cnt_d   = (state_q == BUSY) ? hold_cnt_q + HOLD_W'(1) : '0;
  end

  assign bus.timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  // Scan ptr, ptr+1, ... ptr+7 (mod 8); the first set request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ptr_q + ID_W'(i);
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Release and revocation both move priority just past the grantee.
        if (!bus.req[gnt_id_q] || hold_expired) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  dec3to8 u_dec (
    .id     (gnt_id_q),
    .valid  (gnt_valid_q),
    .onehot (bus.gnt)
  );

  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, hold, wrap, async reset, timeout.
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  logic            clk;
  logic            rst_n;
  arb_state_t      dbg_state;
  logic [ID_W-1:0] dbg_ptr;
  int              checks;
  int              failures;
  logic [7:0]      exp_q[$];
  logic [7:0]      exp_id;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [7:0] r);
    bus.req = r;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] id);
    logic [7:0] one;
    one = 8'h01 << id[2:0];
    chk({tag, "_gnt"}, bus.gnt, one);
    chk({tag, "_id"}, 8'(bus.gnt_id), id);
    chk({tag, "_valid"}, 8'(bus.gnt_valid), 8'h01);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 8'h00);
    chk({tag, "_valid"}, 8'(bus.gnt_valid), 8'h00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_req(8'hFF);

    // Reset with all requests up: everything clear.
    tick();
    tick();
    chk_idle("rst");
    chk("rst_timeout", 8'(bus.timeout), 8'h00);
    chk("rst_ptr", 8'(dbg_ptr), 8'h00);
    chk("rst_state", 8'(dbg_state), 8'(IDLE));
    rst_n = 1'b1;
    tick();
    chk_grant("first", 8'd0);
    chk("first_state", 8'(dbg_state), 8'(BUSY));

    // Rotation with every requester busy: 0,1,...,7,0 then 1.
    for (int i = 0; i < 8; i++) exp_q.push_back(8'((i + 1) % 8));
    exp_q.push_back(8'd1);
    exp_id = 8'd0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_grant("rot_hold", exp_id);
      drive_req(8'hFF & ~(8'h01 << exp_id[2:0]));
      tick();
      chk_idle("rot_gap");
      chk("rot_ptr", 8'(dbg_ptr), 8'((exp_id + 1) % 8));
      drive_req(8'hFF);
      tick();
      exp_id = exp_q.pop_front();
      chk_grant("rot_next", exp_id);
    end
    chk("rot_queue_empty", 8'(exp_q.size()), 8'h00);

    // Grant on 3 holds while other requests appear; next goes to 7.
    drive_req(8'h00);
    tick();
    chk_idle("rel1");
    chk("rel1_ptr", 8'(dbg_ptr), 8'h02);
    drive_req(8'h08);
    tick();
    chk_grant("id3", 8'd3);
    drive_req(8'h8C);
    tick();
    chk_grant("id3_hold_a", 8'd3);
    tick();
    chk_grant("id3_hold_b", 8'd3);
    drive_req(8'h84);
    tick();
    chk_idle("id3_rel");
    chk("id3_rel_ptr", 8'(dbg_ptr), 8'h04);
    tick();
    chk_grant("after3", 8'd7);

    // Move ptr to 6, then 0x41 picks 6 and wraps to 0 afterwards.
    drive_req(8'h00);
    tick();
    chk("rel7_ptr", 8'(dbg_ptr), 8'h00);
    drive_req(8'h20);
    tick();
    chk_grant("id5a", 8'd5);
    drive_req(8'h00);
    tick();
    chk("ptr6", 8'(dbg_ptr), 8'h06);
    drive_req(8'h41);
    tick();
    chk_grant("ptr6_pick", 8'd6);
    drive_req(8'h01);
    tick();
    chk_idle("rel6");
    chk("rel6_ptr", 8'(dbg_ptr), 8'h07);
    tick();
    chk_grant("wrap0", 8'd0);

    // Asynchronous reset mid-grant on id 5.
    drive_req(8'h00);
    tick();
    drive_req(8'h20);
    tick();
    chk_grant("pre_rst", 8'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_ptr", 8'(dbg_ptr), 8'h00);
    chk("async_rst_id", 8'(bus.gnt_id), 8'h00);
    chk("async_rst_state", 8'(dbg_state), 8'(IDLE));
    tick();
    chk_idle("rst_held");
    rst_n = 1'b1;
    tick();
    chk_grant("post_rst", 8'd5);

    // A request pulse that misses every rising edge is never granted.
    drive_req(8'h00);
    tick();
    chk("rel5_ptr", 8'(dbg_ptr), 8'h06);
    #1 drive_req(8'h10);
    #2 drive_req(8'h00);
    tick();
    chk_idle("short_pulse");

`ifdef RR_ARBITER8_TIMEOUT_EN
    // MAX_HOLD=4: id 1 revoked after 4 grant cycles, then id 2.
    drive_req(8'h06);
    tick();
    chk_grant("to_b1", 8'd1);
    tick();
    tick();
    tick();
    chk_grant("to_b4", 8'd1);
    chk("to_b4_pulse", 8'(bus.timeout), 8'h00);
    tick();
    chk_idle("to_revoke");
    chk("to_pulse", 8'(bus.timeout), 8'h01);
    chk("to_ptr", 8'(dbg_ptr), 8'h02);
    tick();
    chk_grant("to_next", 8'd2);
    chk("to_pulse_end", 8'(bus.timeout), 8'h00);
`else
    // Without the timeout feature a grant is held indefinitely.
    drive_req(8'h06);
    tick();
    chk_grant("hold_b1", 8'd1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("hold_gnt", bus.gnt, 8'h02);
      chk("hold_timeout", 8'(bus.timeout), 8'h00);
    end
    drive_req(8'h04);
    tick();
    chk_idle("hold_rel");
    tick();
    chk_grant("hold_next", 8'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among 8 requesters and drives a one-hot 8-bit grant. Each grant is held for as long as its requester holds its request. The block registers a 3-bit winner index and expands it to the one-hot grant vector with a 3:8 decoder stage. It sits in front of any shared datapath (bus, memory port, ALU) whose select lines are one-hot.

## Interface
Parameters:
- MAX_HOLD, 16: maximum number of consecutive BUSY cycles per grant. Used only when the timeout feature is compiled in. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request per requester; bit i is requester i. A requester holds its bit high while it uses the resource.
- gnt  output  8  one-hot grant, or all zeros when idle.
- gnt_id  output  3  index of the current grantee; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State machine, 2 states: IDLE and BUSY. Reset state is IDLE.
- Pointer ptr[2:0] holds the highest-priority index. Reset value is 0.
- IDLE behaviour:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Register the winner into gnt_id, set gnt_valid, go to BUSY.
  - If req == 0, stay in IDLE.
- BUSY behaviour:
  - While req[gnt_id]=1, hold gnt_id and gnt unchanged. Changes on other req bits are ignored.
  - When req[gnt_id]=0 is sampled: clear gnt_valid, set ptr = gnt_id+1 (3-bit wrap, 7→0), go to IDLE.
- gnt = decode(gnt_id) when gnt_valid=1, else 8'h00. gnt is registered-derived and never has more than one bit set.
- Simultaneous requests are resolved by rotating priority only. No requester can win twice in a row while another requester is waiting.
- Reset asserted mid-grant: gnt, gnt_id, gnt_valid, timeout and ptr clear immediately (asynchronously). The state returns to IDLE.

## Timing
- All outputs reset to 0.
- Grant latency: req sampled at edge N (in IDLE) → gnt valid after edge N.
- Release latency: req[gnt_id] sampled low at edge K → gnt = 0 after edge K.
- There is always at least one IDLE cycle between consecutive grants. With continuous requests, the earliest next grant appears after edge K+1.
- A req pulse that is high for fewer than one sampled edge is never granted.

## Configuration
- Macro: RR_ARBITER8_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD with req[gnt_id] still high, the grant is revoked exactly as for a release: ptr advances and the state goes to IDLE.
  - timeout pulses high for one cycle, coincident with the first gnt=0 cycle.
  - The revoked requester may win again only through normal rotation.
- Not defined:
  - No counter logic is built. timeout is tied to 0.
  - A grant is held indefinitely.

## Structure
- Package rr_arbiter8_pkg contains:
  - NUM_REQ=8 and ID_W=3.
  - State enum arb_state_t {IDLE, BUSY}.
  - Hold counter width HOLD_W=8.
- Sub-module dec3to8: purely combinational, gnt_id → 8-bit one-hot, gated by gnt_valid. One instance.
- The rotating priority pick is kept inline in rr_arbiter8.

## Test plan
- Reset with req=8'hFF → gnt=0, gnt_valid=0, timeout=0, ptr=0. After release of reset, first grant is gnt=8'h01, gnt_id=0.
- req=8'hFF held continuously, each grantee drops its req bit for 1 cycle after 2 BUSY cycles → grant order 0,1,…,7,0, with one idle cycle between grants.
- Grant active on id 3 (gnt=8'h08), req changes from 8'h08 to 8'h8C → gnt stays 8'h08 until req[3] drops, then the next grant is id 7.
- ptr=6, req=8'h41 → grant id 6. After release, with req=8'h01, the grant wraps to id 0.
- Assert rst_n=0 while gnt=8'h20 → gnt=0 immediately, without waiting for a clock edge. After reset, req=8'h20 → id 5 is granted (ptr=0, scan 0→5).
- With RR_ARBITER8_TIMEOUT_EN and MAX_HOLD=4, req=8'h06 held continuously:
  - id 1 is revoked after 4 BUSY cycles with timeout=1 for one cycle.
  - id 2 is granted next.
